// File: rtl/sd_data_tx_1bit.sv
`default_nettype none
// ============================================================================
// Module      : sd_data_tx_1bit
// Description : Single-DAT-line SD block write serializer. Frames one block as
//               start bit, data MSB-first, CRC16 and end bit on DAT0, then
//               receives the card's CRC status token and waits out card busy.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_data_tx_1bit #(
    parameter int BLKSIZE = 512,
    parameter int TIMEOUT = 65535
) (
    input  logic       sd_clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       dat_o,
    output logic       dat_oe,
    input  logic       dat_i,
    output logic       busy,
    output logic       done,
    output logic       crc_ok,
    output logic       crc_err,
    output logic [2:0] status,
    output logic       timeout,
    output logic       underrun
);

    localparam int c_NBITS = 8 * BLKSIZE;
    localparam int c_BCW   = $clog2(c_NBITS);
    localparam int c_TCW   = $clog2(TIMEOUT + 1);

    localparam logic [c_BCW-1:0] c_LASTBIT = c_BCW'(c_NBITS - 1);
    localparam logic [c_TCW-1:0] c_TOLAST  = c_TCW'(TIMEOUT - 1);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_PRE   = 4'd1;
    localparam logic [3:0] c_START = 4'd2;
    localparam logic [3:0] c_DATA  = 4'd3;
    localparam logic [3:0] c_CRC   = 4'd4;
    localparam logic [3:0] c_END   = 4'd5;
    localparam logic [3:0] c_WAIT  = 4'd6;
    localparam logic [3:0] c_STAT  = 4'd7;
    localparam logic [3:0] c_STEND = 4'd8;
    localparam logic [3:0] c_BUSY  = 4'd9;

    logic [3:0]       r_state;
    logic [7:0]       r_buf;
    logic             r_full;
    logic [7:0]       r_shift;
    logic [15:0]      r_crc;
    logic [c_BCW-1:0] r_bitcnt;
    logic [3:0]       r_cnt;
    logic [c_TCW-1:0] r_tocnt;
    logic             r_dat_o;
    logic             r_dat_oe;
    logic             r_done;
    logic             r_crc_ok;
    logic             r_crc_err;
    logic [2:0]       r_status;
    logic             r_timeout;
    logic             r_underrun;

    logic             w_din_ready;
    logic             w_wr;

    // x^16 + x^12 + x^5 + 1, MSB-first
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic        inv;
        logic [15:0] n;
        inv   = b ^ c[15];
        n     = {c[14:0], inv};
        n[5]  = n[5] ^ inv;
        n[12] = n[12] ^ inv;
        return n;
    endfunction

    assign w_din_ready = (r_state != c_IDLE) && !r_full;
    assign w_wr        = din_valid && w_din_ready;

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_buf      <= 8'd0;
            r_full     <= 1'b0;
            r_shift    <= 8'd0;
            r_crc      <= 16'd0;
            r_bitcnt   <= '0;
            r_cnt      <= 4'd0;
            r_tocnt    <= '0;
            r_dat_o    <= 1'b1;
            r_dat_oe   <= 1'b0;
            r_done     <= 1'b0;
            r_crc_ok   <= 1'b0;
            r_crc_err  <= 1'b0;
            r_status   <= 3'd0;
            r_timeout  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A write in the same cycle as a load refills the buffer after the load reads it
            if (w_wr) begin
                r_buf  <= din;
                r_full <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    r_dat_oe <= 1'b0;
                    r_dat_o  <= 1'b1;
                    if (start) begin
                        r_state    <= c_PRE;
                        r_crc_ok   <= 1'b0;
                        r_crc_err  <= 1'b0;
                        r_status   <= 3'd0;
                        r_timeout  <= 1'b0;
                        r_underrun <= 1'b0;
                    end
                end
                c_PRE: begin
                    if (r_full) begin
                        r_state  <= c_START;
                        r_dat_oe <= 1'b1;
                        r_dat_o  <= 1'b0;
                        r_crc    <= 16'd0;
                        r_shift  <= r_buf;
                        r_full   <= w_wr;
                    end
                end
                c_START: begin
                    r_state  <= c_DATA;
                    r_dat_o  <= r_shift[7];
                    r_crc    <= crc16_step(r_crc, r_shift[7]);
                    r_shift  <= {r_shift[6:0], 1'b0};
                    r_bitcnt <= '0;
                end
                c_DATA: begin
                    if (r_bitcnt == c_LASTBIT) begin
                        r_state <= c_CRC;
                        r_dat_o <= r_crc[15];
                        r_crc   <= {r_crc[14:0], 1'b0};
                        r_cnt   <= 4'd0;
                    end else if (r_bitcnt[2:0] == 3'd7) begin
                        if (r_full) begin
                            r_dat_o  <= r_buf[7];
                            r_crc    <= crc16_step(r_crc, r_buf[7]);
                            r_shift  <= {r_buf[6:0], 1'b0};
                            r_full   <= w_wr;
                            r_bitcnt <= r_bitcnt + c_BCW'(1);
                        end else begin
                            r_underrun <= 1'b1;
                            r_dat_oe   <= 1'b0;
                            r_dat_o    <= 1'b1;
                            r_done     <= 1'b1;
                            r_full     <= 1'b0;
                            r_state    <= c_IDLE;
                        end
                    end else begin
                        r_dat_o  <= r_shift[7];
                        r_crc    <= crc16_step(r_crc, r_shift[7]);
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_bitcnt <= r_bitcnt + c_BCW'(1);
                    end
                end
                c_CRC: begin
                    if (r_cnt == 4'd15) begin
                        r_state <= c_END;
                        r_dat_o <= 1'b1;
                    end else begin
                        r_dat_o <= r_crc[15];
                        r_crc   <= {r_crc[14:0], 1'b0};
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                c_END: begin
                    r_state  <= c_WAIT;
                    r_dat_oe <= 1'b0;
                    r_dat_o  <= 1'b1;
                    r_tocnt  <= '0;
                end
                c_WAIT: begin
                    if (!dat_i) begin
                        r_state <= c_STAT;
                        r_cnt   <= 4'd0;
                    end else if (r_tocnt == c_TOLAST) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_full    <= 1'b0;
                        r_state   <= c_IDLE;
                    end else begin
                        r_tocnt <= r_tocnt + c_TCW'(1);
                    end
                end
                c_STAT: begin
                    r_status <= {r_status[1:0], dat_i};
                    if (r_cnt == 4'd2) begin
                        r_state <= c_STEND;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_STEND: begin
                    r_state <= c_BUSY;
                    r_tocnt <= '0;
                end
                c_BUSY: begin
                    if (dat_i) begin
                        r_crc_ok  <= (r_status == 3'b010);
                        r_crc_err <= (r_status == 3'b101);
                        r_done    <= 1'b1;
                        r_full    <= 1'b0;
                        r_state   <= c_IDLE;
                    end else if (r_tocnt == c_TOLAST) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_full    <= 1'b0;
                        r_state   <= c_IDLE;
                    end else begin
                        r_tocnt <= r_tocnt + c_TCW'(1);
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_dat_oe <= 1'b0;
                    r_dat_o  <= 1'b1;
                    r_full   <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready = w_din_ready;
    assign dat_o     = r_dat_o;
    assign dat_oe    = r_dat_oe;
    assign busy      = (r_state != c_IDLE);
    assign done      = r_done;
    assign crc_ok    = r_crc_ok;
    assign crc_err   = r_crc_err;
    assign status    = r_status;
    assign timeout   = r_timeout;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_sd_data_tx_1bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_data_tx_1bit
// Description : Directed bench for sd_data_tx_1bit on three block sizes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_data_tx_1bit;

    logic       sd_clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] start;
    logic [2:0] din_valid;
    logic [2:0] dat_i;
    logic [7:0] din [0:2];
    wire  [2:0] din_ready, dat_o, dat_oe, busy, done, crc_ok, crc_err, timeout, underrun;
    wire  [2:0] status [0:2];

    int   tests = 0;
    int   fails = 0;
    logic [7:0] blk [0:599];
    logic       cap [0:4299];

    always #5 sd_clk = ~sd_clk;

    sd_data_tx_1bit #(.BLKSIZE(512), .TIMEOUT(65535)) u_dut0 (
        .sd_clk(sd_clk), .rst(rst[0]), .start(start[0]), .din(din[0]),
        .din_valid(din_valid[0]), .din_ready(din_ready[0]), .dat_o(dat_o[0]),
        .dat_oe(dat_oe[0]), .dat_i(dat_i[0]), .busy(busy[0]), .done(done[0]),
        .crc_ok(crc_ok[0]), .crc_err(crc_err[0]), .status(status[0]),
        .timeout(timeout[0]), .underrun(underrun[0]));

    sd_data_tx_1bit #(.BLKSIZE(4), .TIMEOUT(20)) u_dut1 (
        .sd_clk(sd_clk), .rst(rst[1]), .start(start[1]), .din(din[1]),
        .din_valid(din_valid[1]), .din_ready(din_ready[1]), .dat_o(dat_o[1]),
        .dat_oe(dat_oe[1]), .dat_i(dat_i[1]), .busy(busy[1]), .done(done[1]),
        .crc_ok(crc_ok[1]), .crc_err(crc_err[1]), .status(status[1]),
        .timeout(timeout[1]), .underrun(underrun[1]));

    sd_data_tx_1bit #(.BLKSIZE(9), .TIMEOUT(20)) u_dut2 (
        .sd_clk(sd_clk), .rst(rst[2]), .start(start[2]), .din(din[2]),
        .din_valid(din_valid[2]), .din_ready(din_ready[2]), .dat_o(dat_o[2]),
        .dat_oe(dat_oe[2]), .dat_i(dat_i[2]), .busy(busy[2]), .done(done[2]),
        .crc_ok(crc_ok[2]), .crc_err(crc_err[2]), .status(status[2]),
        .timeout(timeout[2]), .underrun(underrun[2]));

    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    task automatic start_pulse(input int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    // Feeds blk[0..navail-1] and records every DAT0 bit while dat_oe is high.
    task automatic send_block(input int k, input int navail, input int abort_at,
                              output int nbits, output int oe_cyc, output logic done_at_drop);
        int   idx;
        logic pend;
        logic seen;
        idx = 0; seen = 1'b0; nbits = 0; oe_cyc = -1; done_at_drop = 1'b0;
        din[k]       = blk[0];
        din_valid[k] = (navail > 0);
        pend         = din_valid[k] && din_ready[k];
        for (int cyc = 1; cyc < 5000; cyc++) begin
            tick();
            if (pend) idx++;
            if (dat_oe[k]) begin
                if (oe_cyc < 0) oe_cyc = cyc;
                if (nbits < 4300) cap[nbits] = dat_o[k];
                nbits++;
                seen = 1'b1;
            end else if (seen) begin
                done_at_drop = done[k];
                break;
            end
            if (abort_at > 0 && nbits == abort_at) break;
            din[k]       = blk[idx];
            din_valid[k] = (idx < navail);
            pend         = din_valid[k] && din_ready[k];
        end
        din_valid[k] = 1'b0;
    endtask

    // Plays seq MSB-first on dat_i from WAIT_ST entry, holding the last bit; n = edges until done.
    task automatic respond(input int k, input logic [15:0] seq, input int nseq, output int n);
        n = -1;
        for (int i = 0; i < 200; i++) begin
            dat_i[k] = (i < nseq) ? seq[nseq-1-i] : seq[0];
            tick();
            if (done[k]) begin
                n = i + 1;
                break;
            end
        end
        dat_i[k] = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst = 3'b111; start = 3'b000; din_valid = 3'b111; dat_i = 3'b111;
        for (int k = 0; k < 3; k++) din[k] = 8'hA5;
        repeat (3) tick();
        rst = 3'b000;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            got = {dat_o[k], dat_oe[k], din_ready[k], busy[k], done[k], crc_ok[k],
                   crc_err[k], timeout[k], underrun[k], status[k]};
            tests++;
            if (got !== 12'b1000_0000_0000) begin
                fails++;
                $display("FAIL reset_state[%0d]: got %b expected %b", k, got, 12'b1000_0000_0000);
            end
        end
        din_valid = 3'b000;
    endtask

    task automatic test_full_block();
        int   nbits, oe_cyc, bad, n;
        logic dad;
        logic [15:0] crc;
        for (int i = 0; i < 600; i++) blk[i] = 8'hFF;
        start_pulse(0);
        tests++;
        if ({busy[0], din_ready[0]} !== 2'b11) begin
            fails++;
            $display("FAIL start_busy_ready: got %b expected 11", {busy[0], din_ready[0]});
        end
        send_block(0, 512, 0, nbits, oe_cyc, dad);
        // first byte taken at edge 1, so START appears from edge 2
        tests++;
        if (oe_cyc !== 2) begin
            fails++;
            $display("FAIL start_latency: got %0d expected 2", oe_cyc);
        end
        tests++;
        if (nbits !== 4114) begin
            fails++;
            $display("FAIL frame_len_512: got %0d expected 4114", nbits);
        end
        bad = 0;
        for (int i = 0; i < 4096; i++) if (cap[1+i] !== 1'b1) bad++;
        crc = 16'd0;
        for (int j = 0; j < 16; j++) crc = {crc[14:0], cap[4097+j]};
        tests++;
        if ({cap[0], cap[4113]} !== 2'b01 || bad != 0) begin
            fails++;
            $display("FAIL frame_ff_bits: start/end %b bad data %0d expected 01 and 0", {cap[0], cap[4113]}, bad);
        end
        tests++;
        if (crc !== 16'h7FA1) begin
            fails++;
            $display("FAIL crc_ff_512: got %h expected 7fa1", crc);
        end
        respond(0, 16'b0010100001, 10, n);
        tests++;
        if (n !== 10) begin
            fails++;
            $display("FAIL done_latency_ok: got %0d expected 10", n);
        end
        tests++;
        if ({crc_ok[0], crc_err[0], timeout[0], underrun[0], status[0], busy[0]} !== 8'b1000_0100) begin
            fails++;
            $display("FAIL flags_ok: got %b expected 10000100",
                     {crc_ok[0], crc_err[0], timeout[0], underrun[0], status[0], busy[0]});
        end
        tick();
        tests++;
        if ({done[0], crc_ok[0]} !== 2'b01) begin
            fails++;
            $display("FAIL done_one_cycle: got %b expected 01", {done[0], crc_ok[0]});
        end
    endtask

    task automatic test_zero_block();
        int   nbits, oe_cyc, bad, n;
        logic dad;
        logic [15:0] crc;
        for (int i = 0; i < 8; i++) blk[i] = 8'h00;
        start_pulse(1);
        // a fifth byte is offered and must be discarded when done
        send_block(1, 5, 0, nbits, oe_cyc, dad);
        bad = 0;
        for (int i = 0; i < 32; i++) if (cap[1+i] !== 1'b0) bad++;
        crc = 16'hFFFF;
        for (int j = 0; j < 16; j++) crc = {crc[14:0], cap[33+j]};
        tests++;
        if (nbits !== 50 || bad != 0 || crc !== 16'h0000 || cap[49] !== 1'b1) begin
            fails++;
            $display("FAIL zero_block: len %0d bad %0d crc %h end %b expected 50 0 0000 1",
                     nbits, bad, crc, cap[49]);
        end
        respond(1, 16'b01011, 5, n);
        tests++;
        if (n !== 6 || {crc_ok[1], crc_err[1], status[1]} !== 5'b01101) begin
            fails++;
            $display("FAIL crc_err_token: n %0d flags %b expected 6 01101", n, {crc_ok[1], crc_err[1], status[1]});
        end
    endtask

    task automatic test_back_to_back();
        // start presented in the done cycle
        start_pulse(1);
        tests++;
        if ({busy[1], crc_err[1], status[1]} !== 5'b10000) begin
            fails++;
            $display("FAIL b2b_start: got %b expected 10000", {busy[1], crc_err[1], status[1]});
        end
        repeat (3) tick();
        tests++;
        if ({dat_oe[1], din_ready[1]} !== 2'b01) begin
            fails++;
            $display("FAIL stale_byte_dropped: got %b expected 01", {dat_oe[1], din_ready[1]});
        end
    endtask

    task automatic test_underrun();
        int   nbits, oe_cyc;
        logic dad;
        logic [7:0] got;
        blk[0] = 8'hC3;
        send_block(1, 1, 0, nbits, oe_cyc, dad);
        got = 8'd0;
        for (int i = 0; i < 8; i++) got = {got[6:0], cap[1+i]};
        tests++;
        if (nbits !== 9 || dad !== 1'b1 || got !== 8'hC3) begin
            fails++;
            $display("FAIL underrun_frame: len %0d done %b byte %h expected 9 1 c3", nbits, dad, got);
        end
        tests++;
        if ({underrun[1], timeout[1], crc_ok[1], busy[1], dat_o[1]} !== 5'b10001) begin
            fails++;
            $display("FAIL underrun_flags: got %b expected 10001",
                     {underrun[1], timeout[1], crc_ok[1], busy[1], dat_o[1]});
        end
    endtask

    task automatic test_timeout_wait();
        int   nbits, oe_cyc, n;
        logic dad;
        blk[0] = 8'h11; blk[1] = 8'h22; blk[2] = 8'h33; blk[3] = 8'h44;
        start_pulse(1);
        send_block(1, 4, 0, nbits, oe_cyc, dad);
        respond(1, 16'b1, 1, n);
        tests++;
        if (n !== 20 || {timeout[1], underrun[1], crc_ok[1], crc_err[1], status[1]} !== 7'b1000000) begin
            fails++;
            $display("FAIL timeout_wait: n %0d flags %b expected 20 1000000",
                     n, {timeout[1], underrun[1], crc_ok[1], crc_err[1], status[1]});
        end
    endtask

    task automatic test_timeout_busy();
        int   nbits, oe_cyc, n;
        logic dad;
        start_pulse(1);
        send_block(1, 4, 0, nbits, oe_cyc, dad);
        respond(1, 16'b001010, 6, n);
        tests++;
        if (n !== 25 || {timeout[1], status[1]} !== 4'b1010) begin
            fails++;
            $display("FAIL timeout_busy: n %0d flags %b expected 25 1010", n, {timeout[1], status[1]});
        end
    endtask

    task automatic test_reset_mid_data();
        int   nbits, oe_cyc, bad, n;
        logic dad;
        logic [15:0] crc;
        for (int i = 0; i < 9; i++) blk[i] = 8'h31 + 8'(i);
        start_pulse(2);
        send_block(2, 9, 20, nbits, oe_cyc, dad);
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        tests++;
        if ({dat_oe[2], dat_o[2], busy[2], din_ready[2]} !== 4'b0100) begin
            fails++;
            $display("FAIL rst_mid_data: got %b expected 0100", {dat_oe[2], dat_o[2], busy[2], din_ready[2]});
        end
        tick();
        start_pulse(2);
        send_block(2, 9, 0, nbits, oe_cyc, dad);
        bad = 0;
        for (int i = 0; i < 72; i++) if (cap[1+i] !== blk[i/8][7-(i%8)]) bad++;
        crc = 16'd0;
        for (int j = 0; j < 16; j++) crc = {crc[14:0], cap[73+j]};
        tests++;
        if (nbits !== 90 || bad != 0 || crc !== 16'h31C3) begin
            fails++;
            $display("FAIL after_rst_block: len %0d bad %0d crc %h expected 90 0 31c3", nbits, bad, crc);
        end
        respond(2, 16'b001011, 6, n);
        tests++;
        if (n !== 6 || {crc_ok[2], crc_err[2], status[2]} !== 5'b10010) begin
            fails++;
            $display("FAIL after_rst_token: n %0d flags %b expected 6 10010", n, {crc_ok[2], crc_err[2], status[2]});
        end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_zero_block();
        test_back_to_back();
        test_underrun();
        test_timeout_wait();
        test_timeout_busy();
        test_reset_mid_data();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sd_data_tx_1bit.md
# sd_data_tx_1bit

Single-DAT-line SD block write serializer. Takes a block of bytes over a valid/ready byte stream, frames it on DAT0 as start bit, data MSB-first, CRC16 and end bit, then receives the card's CRC status token and waits out card busy. Sits between the controller's write-data buffer and the DAT0 pad. CRC16 is generated in-core on the SD card clock with the CRC16 unit's polynomial, x^16+x^12+x^5+1, init 0, no separate strobe clock.

## Interface
- BLKSIZE, 512: bytes per block, 1..2048.
- TIMEOUT, 65535: max sd_clk cycles allowed in each of WAIT_ST and BUSY.
- sd_clk  in  1  card clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins one block write when in IDLE; ignored otherwise.
- din  in  8  write byte.
- din_valid  in  1  din holds a byte.
- din_ready  out  1  one-byte holding buffer empty; a byte transfers when din_valid & din_ready.
- dat_o  out  1  DAT0 output value.
- dat_oe  out  1  DAT0 output enable.
- dat_i  in  1  DAT0 input, already synchronized.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the block finishes, successfully or not.
- crc_ok  out  1  valid with done: status token was 010.
- crc_err  out  1  valid with done: status token was 101.
- status  out  3  last received status bits; held until next start.
- timeout  out  1  valid with done: WAIT_ST or BUSY expired.
- underrun  out  1  valid with done: holding buffer empty at a byte load.

## Operation
- States: IDLE, PRE, START, DATA, CRC, END, WAIT_ST, STAT, STEND, BUSYW.
- IDLE: dat_oe=0, dat_o=1. start moves to PRE and clears all flags and status.
- PRE: wait until the holding buffer is full, then go to START.
- START: drive 0 for one cycle. Clear CRC. Load the shift register from the buffer, which empties it.
- DATA: 8*BLKSIZE cycles, bit 7 first. Each driven bit enters the CRC LFSR: inv=bit^crc[15]; shift left; crc[0]=inv; crc[5]^=inv; crc[12]^=inv.
- At the 8th bit of each non-final byte, reload from the buffer. If the buffer is empty then, set underrun, drop dat_oe, pulse done and return to IDLE.
- CRC: 16 cycles driving crc[15] first. The LFSR is frozen and shifted out.
- END: drive 1 for one cycle. Next state WAIT_ST with dat_oe=0.
- WAIT_ST: sample dat_i. The first 0 is the token start bit; go to STAT.
- STAT: capture 3 bits MSB-first into status. Go to STEND.
- STEND: ignore the sampled end-bit value. Go to BUSYW.
- BUSYW: stay while dat_i=0. On the first dat_i=1, pulse done and return to IDLE. crc_ok = (status==3'b010); crc_err = (status==3'b101).
- The timeout counter restarts on entry to WAIT_ST and on entry to BUSYW. When it reaches TIMEOUT, set timeout, pulse done and go to IDLE.
- The holding buffer accepts bytes in any state except IDLE. A byte offered in IDLE is not taken: din_ready=0.
- The buffer is cleared on done, so bytes beyond BLKSIZE are never consumed.
- Bit counter width is clog2(8*BLKSIZE). It wraps only via the explicit state exit.

## Timing
- Reset values: dat_o=1, dat_oe=0, din_ready=0, busy=0, done=0, crc_ok=0, crc_err=0, status=0, timeout=0, underrun=0. The FSM is in IDLE and the buffer is empty.
- rst mid-operation: IDLE on the next edge. dat_oe drops in that cycle; there is no end bit or partial CRC.
- start registered at edge 0: busy=1 and din_ready=1 from edge 1.
- If a byte is accepted at edge k, START (dat_oe=1, dat_o=0) is driven from edge k+1.
- Data bit n is driven at START+1+n. The CRC MSB is driven at START+1+8*BLKSIZE. END is driven at START+17+8*BLKSIZE.
- dat_oe=0 from START+18+8*BLKSIZE.
- din_ready rises the cycle after a load. The upstream has 7 cycles to supply the next byte.
- Simultaneous load and new write in the same cycle: the load takes the old byte and the new byte fills the buffer; this is legal.
- done is exactly one cycle and is coincident with the first IDLE cycle's flags being valid. Flags hold until the next start.
- start in the same cycle as done's return to IDLE is accepted.

## Test plan
- BLKSIZE=512, all bytes 0xFF, card returns 0,010,1 then 4 busy cycles → on DAT0: 0, 4096 ones, CRC 0x7FA1, 1. done with crc_ok=1 and status=010, 5 cycles after the status end bit.
- BLKSIZE=4, bytes 00 00 00 00 → CRC 0x0000 driven. Token 0,101,1 → crc_err=1, crc_ok=0.
- BLKSIZE=4, din_valid held low after the first byte → underrun=1 and done at the byte-1 load. dat_oe=0 the next cycle; no CRC bits driven.
- TIMEOUT=20, dat_i held 1 after END → timeout=1 with done exactly 20 cycles after WAIT_ST entry.
- Same setup, dat_i held 0 after the token → timeout in BUSYW after 20 cycles.
- rst asserted mid-DATA → next cycle dat_oe=0, dat_o=1, busy=0. A new start then writes a correct block, checked by the CRC.
